// File: rtl/keypad_encoder.sv
// Debounced 10-key decimal keypad encoder: one BCD digit plus a one-cycle loadn strobe per keystroke.
// Optional KEYPAD_SYNC_EN inserts a 2-flop synchronizer on the raw key lines.
module keypad_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] keys,
    output logic [3:0] data,
    output logic       loadn,
    output logic       busy
);

    localparam int unsigned KEY_N  = 10;
    localparam int unsigned CODE_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_EMIT,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [KEY_N-1:0]    r_pat;
    logic [KEY_N-1:0]    w_pat_nxt;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [CODE_W-1:0]   r_data;
    logic                r_loadn;
    logic                r_busy;

    logic [KEY_N-1:0]    w_ks;
    logic                w_onehot;
    logic                w_none;
    logic [CODE_W-1:0]   w_enc;

`ifdef KEYPAD_SYNC_EN
    logic [KEY_N-1:0]    r_sync1;
    logic [KEY_N-1:0]    r_sync2;

    // Two-stage synchronizer for the asynchronous key lines
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= keys;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ks = r_sync2;
`else
    assign w_ks = keys;
`endif

    // Exactly one key pressed: nonzero and clearing the lowest set bit leaves nothing
    assign w_none   = (w_ks == '0);
    assign w_onehot = !w_none && ((w_ks & (w_ks - KEY_N'(1))) == '0);

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < int'(KEY_N); i++) begin
            if (w_ks[i]) begin
                w_enc = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pat   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pat   <= w_pat_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // Counter is compared before increment and cleared on every state entry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pat_nxt   = r_pat;
        w_code_nxt  = r_code;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_pat_nxt   = w_ks;
                    w_code_nxt  = w_enc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (w_ks == r_pat) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_EMIT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_none) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (w_none) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so the strobe coincides with EMIT
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_data  <= '0;
            r_loadn <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            if (w_state_nxt == S_EMIT) begin
                r_data <= r_code;
            end
            r_loadn <= (w_state_nxt != S_EMIT);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign data  = r_data;
    assign loadn = r_loadn;
    assign busy  = r_busy;

endmodule
